// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Arbitrates between two writeback sources, the integer pipe (IP) and the
// load/store pipe (LS), and accepts at most one request per cycle.  The
// accepted request is registered and presented one cycle later on the
// register-file write port, the issue scoreboard clear port and the retire
// port.
//
// Handshake: a request is accepted in a cycle where its valid and ready are
// both 1.  Ready is combinational and is given only to the arbitration winner.
// Nothing is buffered here; a source whose request is not accepted must hold
// it stable until it sees ready.
//
// Arbitration order:
//   1. LS, if it has been starved for STARVE_LIMIT consecutive cycles
//   2. IP, if it carries a resolved branch (ip_wb_hipri)
//   3. round-robin pointer, when both are valid
//   4. the only valid source
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   ip_wb_*                  integer pipe request (dst/result/pc/wb_en/hipri/valid),
//                            ip_wb_ready back to the pipe
//   lp_wb_*                  load/store pipe request (dst/result/pc/wb_en/valid),
//                            lp_wb_ready back to the pipe
//   rf_wr_en/id/data         register file write port (registered)
//   wb_ix_clr/clr_dst        scoreboard clear to issue (registered)
//   wb_retire_pc/valid/count retire information (registered)
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [4:0]  ip_wb_dst,
    input  logic [63:0] ip_wb_result,
    input  logic [63:0] ip_wb_pc,
    input  logic        ip_wb_wb_en,
    input  logic        ip_wb_hipri,
    input  logic        ip_wb_valid,
    output logic        ip_wb_ready,

    input  logic [4:0]  lp_wb_dst,
    input  logic [63:0] lp_wb_result,
    input  logic [63:0] lp_wb_pc,
    input  logic        lp_wb_wb_en,
    input  logic        lp_wb_valid,
    output logic        lp_wb_ready,

    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_id,
    output logic [63:0] rf_wr_data,

    output logic        wb_ix_clr,
    output logic [4:0]  wb_ix_clr_dst,

    output logic [63:0] wb_retire_pc,
    output logic        wb_retire_valid,
    output logic [63:0] wb_retire_count
);

    // A zero limit would give a zero-width counter; keep at least one bit.
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic {
        SRC_IP = 1'b0,
        SRC_LS = 1'b1
    } src_e;

    src_e          rr_q, rr_d;
    logic [CW-1:0] starve_q, starve_d;

    logic          grant_ip;
    logic          grant_ls;
    logic          accept;
    logic          both_valid;

    logic [4:0]    sel_dst;
    logic [63:0]   sel_result;
    logic [63:0]   sel_pc;
    logic          sel_wb_en;

    logic          rf_wr_en_q;
    logic [4:0]    rf_wr_id_q;
    logic [63:0]   rf_wr_data_q;
    logic [63:0]   retire_pc_q;
    logic          retire_valid_q;
    logic [63:0]   retire_count_q;

    assign both_valid = ip_wb_valid && lp_wb_valid;

    // Winner selection; no grant at all while reset is asserted.
    always_comb begin
        grant_ip = 1'b0;
        grant_ls = 1'b0;
        if (rst) begin
            if (lp_wb_valid && (starve_q == STARVE_MAX)) begin
                grant_ls = 1'b1;
            end else if (ip_wb_valid && ip_wb_hipri) begin
                grant_ip = 1'b1;
            end else if (both_valid) begin
                if (rr_q == SRC_LS) begin
                    grant_ls = 1'b1;
                end else begin
                    grant_ip = 1'b1;
                end
            end else if (ip_wb_valid) begin
                grant_ip = 1'b1;
            end else if (lp_wb_valid) begin
                grant_ls = 1'b1;
            end
        end
    end

    assign ip_wb_ready = grant_ip;
    assign lp_wb_ready = grant_ls;
    assign accept      = grant_ip || grant_ls;

    // Round-robin pointer moves to the loser only when there was contention.
    // Starvation counter tracks consecutive LS losses while LS keeps asking.
    always_comb begin
        rr_d     = rr_q;
        starve_d = starve_q;
        if (both_valid && accept) begin
            rr_d = grant_ip ? SRC_LS : SRC_IP;
        end
        if (!lp_wb_valid || grant_ls) begin
            starve_d = '0;
        end else if (grant_ip && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Payload of the winning source.
    always_comb begin
        sel_dst    = ip_wb_dst;
        sel_result = ip_wb_result;
        sel_pc     = ip_wb_pc;
        sel_wb_en  = ip_wb_wb_en;
        if (grant_ls) begin
            sel_dst    = lp_wb_dst;
            sel_result = lp_wb_result;
            sel_pc     = lp_wb_pc;
            sel_wb_en  = lp_wb_wb_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q           <= SRC_IP;
            starve_q       <= '0;
            rf_wr_en_q     <= 1'b0;
            rf_wr_id_q     <= '0;
            rf_wr_data_q   <= '0;
            retire_pc_q    <= '0;
            retire_valid_q <= 1'b0;
            retire_count_q <= '0;
        end else begin
            rr_q           <= rr_d;
            starve_q       <= starve_d;
            // Writes to x0 retire but never touch the register file.
            rf_wr_en_q     <= accept && sel_wb_en && (sel_dst != 5'd0);
            retire_valid_q <= accept;
            if (accept) begin
                rf_wr_id_q     <= sel_dst;
                rf_wr_data_q   <= sel_result;
                retire_pc_q    <= sel_pc;
                retire_count_q <= retire_count_q + 64'd1;
            end
        end
    end

    assign rf_wr_en        = rf_wr_en_q;
    assign rf_wr_id        = rf_wr_id_q;
    assign rf_wr_data      = rf_wr_data_q;
    assign wb_ix_clr       = rf_wr_en_q;
    assign wb_ix_clr_dst   = rf_wr_id_q;
    assign wb_retire_pc    = retire_pc_q;
    assign wb_retire_valid = retire_valid_q;
    assign wb_retire_count = retire_count_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive cycles a valid LS request may lose arbitration.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  sole clock, rising edge.
 rst  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low.
 ip_wb_dst  in  5  integer pipe destination register.
 ip_wb_result  in  64  integer pipe result.
 ip_wb_pc  in  64  integer pipe instruction PC.
 ip_wb_wb_en  in  1  integer pipe register write requested.
 ip_wb_hipri  in  1  integer pipe carries a resolved branch; high priority.
 ip_wb_valid  in  1  integer pipe request valid.
 ip_wb_ready  out  1  integer pipe request accepted this cycle.
 lp_wb_dst  in  5  load/store pipe destination register.
 lp_wb_result  in  64  load/store pipe result.
 lp_wb_pc  in  64  load/store pipe instruction PC.
 lp_wb_wb_en  in  1  load/store pipe register write requested.
 lp_wb_valid  in  1  load/store pipe request valid.
 lp_wb_ready  out  1  load/store pipe request accepted this cycle.
 rf_wr_en  out  1  register file write strobe.
 rf_wr_id  out  5  register file write index.
 rf_wr_data  out  64  register file write data.
 wb_ix_clr  out  1  scoreboard clear strobe to issue.
 wb_ix_clr_dst  out  5  scoreboard entry to clear.
 wb_retire_pc  out  64  PC of instruction retired this cycle.
 wb_retire_valid  out  1  one instruction retired this cycle.
 wb_retire_count  out  64  total retired instructions since reset.

Function
REQ-003 SHALL accept at most one request per cycle; a request is accepted when its valid and ready are both 1 in the same cycle.
REQ-004 SHALL drive ready combinationally: ready=1 only to the arbitration winner; loser ready=0; with a single valid source that source gets ready=1.
REQ-005 SHALL select winner in priority order: (a) LS if lp valid and starve_cnt==STARVE_LIMIT; (b) IP if ip valid and ip_wb_hipri; (c) with both valid and no hipri, source indicated by round-robin pointer rr; (d) otherwise the only valid source.
REQ-006 SHALL hold rr as 1-bit state; after any accept with both sources valid, rr points to the source that lost; otherwise rr unchanged.
REQ-007 SHALL hold starve_cnt (width clog2(STARVE_LIMIT+1)); increment when lp valid and LS loses; clear to 0 when LS accepted or lp_wb_valid=0; never exceed STARVE_LIMIT.
REQ-008 SHALL register all outputs except ready: accepted request appears on rf_*/wb_ix_*/wb_retire_* exactly one cycle after acceptance; latency 1, throughput 1/cycle.
REQ-009 SHALL assert rf_wr_en and wb_ix_clr only when accepted wb_en=1 and dst!=0; rf_wr_id and wb_ix_clr_dst = accepted dst; rf_wr_data = accepted result.
REQ-010 SHALL assert wb_retire_valid for every accepted request regardless of wb_en or dst; wb_retire_pc = accepted PC.
REQ-011 SHALL increment wb_retire_count by 1 per accepted request, wrapping modulo 2^64.
REQ-012 SHALL deassert rf_wr_en, wb_ix_clr, wb_retire_valid in cycles following no acceptance; data outputs may hold prior values.
REQ-013 SHALL not buffer: an unaccepted request is the source's responsibility to hold stable until ready.

Reset
REQ-014 SHALL, when rst=0 at a rising edge: rf_wr_en=0, wb_ix_clr=0, wb_retire_valid=0, wb_retire_count=0, rr=IP, starve_cnt=0; rf_wr_id, wb_ix_clr_dst=0; rf_wr_data, wb_retire_pc=0.
REQ-015 SHALL force both readys to 0 while rst=0; requests presented during reset are not accepted and do not retire; reset mid-stream discards nothing already registered beyond clearing outputs.

Verification
REQ-016 Single IP request dst=5, result=0x1234, wb_en=1 -> ip ready same cycle; next cycle rf_wr_en=1, rf_wr_id=5, rf_wr_data=0x1234, wb_ix_clr=1, count=1.
REQ-017 Both valid, no hipri, held 4 cycles after reset -> winners IP, LS, IP, LS; count=4.
REQ-018 IP hipri valid every cycle, LS valid, STARVE_LIMIT=3 -> IP wins 3 cycles, LS wins 4th, starve_cnt returns 0, IP wins 5th.
REQ-019 LS request dst=0, wb_en=1, pc=0x8000_0010 -> rf_wr_en=0, wb_ix_clr=0, wb_retire_valid=1, wb_retire_pc=0x8000_0010.
REQ-020 rst=0 asserted one cycle while both valid after 10 retirements -> no ready, count=0, rr=IP; after release IP wins first.
